// File: rtl/dff_bank_write_arbiter_if.sv
// Bus bundle between the write requesters and the shared-register arbiter.
//
// Parameters: N requesters, WIDTH data bits, PTR_W owner index bits.
// Signals:
//   req       N        level request per requester, held until ack
//   req_data  N*WIDTH  write data, requester i on bits [i*WIDTH +: WIDTH]
//   lock      N        burst lock per requester (only with DFF_ARB_LOCK_EN)
//   gnt       N        one-hot grant
//   ack       N        one-cycle commit pulse at the granted bit
//   q         WIDTH    shared register contents
//   q_valid   1        register written at least once since reset
//   q_owner   PTR_W    index of the last writer
// Modports: master = requester side, slave = arbiter side.
interface dff_bank_write_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int PTR_W = $clog2(N)
);
    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] req_data;
`ifdef DFF_ARB_LOCK_EN
    logic [N-1:0]       lock;
`endif
    logic [N-1:0]       gnt;
    logic [N-1:0]       ack;
    logic [WIDTH-1:0]   q;
    logic               q_valid;
    logic [PTR_W-1:0]   q_owner;

`ifdef DFF_ARB_LOCK_EN
    modport master (output req, req_data, lock,
                    input  gnt, ack, q, q_valid, q_owner);
    modport slave  (input  req, req_data, lock,
                    output gnt, ack, q, q_valid, q_owner);
`else
    modport master (output req, req_data,
                    input  gnt, ack, q, q_valid, q_owner);
    modport slave  (input  req, req_data,
                    output gnt, ack, q, q_valid, q_owner);
`endif
endinterface

// File: rtl/dff_bank_write_arbiter.sv
// Round-robin write arbiter for a shared WIDTH-bit register. N requesters
// take turns loading the register, one write per grant, with a one-hot
// grant and a one-cycle ack on the commit cycle.
//
// Ports:
//   clk  clock, rising edge
//   rst  synchronous reset, active-high, highest priority
//   bus  dff_bank_write_arbiter_if.slave (req, req_data, [lock], gnt, ack,
//        q, q_valid, q_owner)
//
// Optional feature: define DFF_ARB_LOCK_EN to add the per-requester lock
// input. A granted requester holding lock and req in its commit cycle keeps
// the grant and writes again two cycles later without rr_ptr advancing.
//
// state | meaning
// IDLE  | no grant; arbitrate req from rr_ptr upward with wrap
// GRANT | gnt[sel] high; commit next edge if req[sel] still high, else drop
// WRITE | q/q_owner/ack updated for sel; release (or re-grant under lock)
module dff_bank_write_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int PTR_W = $clog2(N)
) (
    input logic                     clk,
    input logic                     rst,
    dff_bank_write_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t           state;
    logic [N-1:0]     gnt_r;
    logic [N-1:0]     ack_r;
    logic [WIDTH-1:0] q_r;
    logic             q_valid_r;
    logic [PTR_W-1:0] q_owner_r;
    logic [PTR_W-1:0] sel;
    logic [PTR_W-1:0] rr_ptr;

    logic             win_found;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W-1:0] scan_idx;
    logic [N-1:0]     win_onehot;
    logic [N-1:0]     sel_onehot;
    logic             sel_req;
    logic [WIDTH-1:0] sel_data;
    logic [PTR_W-1:0] sel_next;
    logic             burst_hold;

    // First set request at or after rr_ptr, wrapping past N-1 to 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < N; k++) begin
            scan_idx = PTR_W'((int'(rr_ptr) + k) % N);
            if (!win_found && bus.req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < N; k++) begin
            if (sel == PTR_W'(k)) begin
                sel_data = bus.req_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign sel_req    = bus.req[sel];
    assign win_onehot = N'(1) << win_idx;
    assign sel_onehot = N'(1) << sel;
    // Explicit wrap so non-power-of-two N never yields an index >= N.
    assign sel_next   = (sel == PTR_W'(N - 1)) ? '0 : sel + PTR_W'(1);

`ifdef DFF_ARB_LOCK_EN
    assign burst_hold = bus.lock[sel] & sel_req;
`else
    assign burst_hold = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt_r     <= '0;
            ack_r     <= '0;
            q_r       <= '0;
            q_valid_r <= 1'b0;
            q_owner_r <= '0;
            sel       <= '0;
            rr_ptr    <= '0;
        end else begin
            ack_r <= '0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        gnt_r <= win_onehot;
                        sel   <= win_idx;
                        state <= GRANT;
                    end else begin
                        gnt_r <= '0;
                    end
                end
                GRANT: begin
                    // The commit is registered on entry to WRITE so that
                    // q/q_owner/ack are visible for the whole WRITE cycle.
                    if (sel_req) begin
                        q_r       <= sel_data;
                        q_valid_r <= 1'b1;
                        q_owner_r <= sel;
                        ack_r     <= sel_onehot;
                        state     <= WRITE;
                    end else begin
                        gnt_r <= '0;
                        state <= IDLE;
                    end
                end
                WRITE: begin
                    if (burst_hold) begin
                        state <= GRANT;
                    end else begin
                        rr_ptr <= sel_next;
                        gnt_r  <= '0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    gnt_r <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt     = gnt_r;
    assign bus.ack     = ack_r;
    assign bus.q       = q_r;
    assign bus.q_valid = q_valid_r;
    assign bus.q_owner = q_owner_r;
endmodule
